// File: rtl/qsys_pwm_core.sv
// Avalon-MM controlled single-channel PWM generator with shadowed period/duty reload.
// New period/duty values apply at a period wrap, on a load_now command, or immediately while disabled.
module qsys_pwm_core #(
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        pwm_out,
    output logic [7:0]  status
);

    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrPeriod = 2'd1;
    localparam logic [1:0] AddrDuty   = 2'd2;
    localparam logic [1:0] AddrCmd    = 2'd3;

    // Software-visible registers
    logic [1:0]       ctrl_q,       ctrl_d;
    logic [CNT_W-1:0] period_reg_q, period_reg_d;
    logic [CNT_W-1:0] duty_reg_q,   duty_reg_d;

    // Active shadows and counter state
    logic [CNT_W-1:0] period_act_q, period_act_d;
    logic [CNT_W-1:0] duty_act_q,   duty_act_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             run_q,        run_d;
    logic [2:0]       wrap_cnt_q,   wrap_cnt_d;

    // Registered outputs
    logic             pwm_q,        pwm_d;
    logic [7:0]       status_q,     status_d;
    logic [31:0]      readdata_q,   readdata_d;

    // Bus decode
    logic wr_en;
    logic wr_ctrl;
    logic wr_period;
    logic wr_duty;
    logic wr_cmd;
    logic load_now;
    logic clr_wrap;

    // Datapath helpers
    logic enable;
    logic invert;
    logic active;
    logic at_end;
    logic wrap;
    logic shadow_load;
    logic raw;
    logic pending;

    logic unused_wdata;
    assign unused_wdata = ^writedata[31:CNT_W];

    assign wr_en     = chipselect & ~write_n;
    assign wr_ctrl   = wr_en & (address == AddrCtrl);
    assign wr_period = wr_en & (address == AddrPeriod);
    assign wr_duty   = wr_en & (address == AddrDuty);
    assign wr_cmd    = wr_en & (address == AddrCmd);
    assign load_now  = wr_cmd & writedata[0];
    assign clr_wrap  = wr_cmd & writedata[1];

    assign enable = ctrl_q[0];
    assign invert = ctrl_q[1];

    // run_q is enable delayed one cycle: the counter sits at 0 for one cycle after enabling,
    // and the output keeps tracking the counter for one cycle after disabling.
    assign active      = enable & run_q;
    assign at_end      = (cnt_q == period_act_q);
    assign wrap        = active & (at_end | load_now);
    assign shadow_load = ~enable | wrap | load_now;
    assign raw         = (cnt_q < duty_act_q);
    assign pending     = (period_reg_q != period_act_q) | (duty_reg_q != duty_act_q);

    always_comb begin
        ctrl_d       = ctrl_q;
        period_reg_d = period_reg_q;
        duty_reg_d   = duty_reg_q;
        if (wr_ctrl) begin
            ctrl_d = writedata[1:0];
        end
        if (wr_period) begin
            period_reg_d = writedata[CNT_W-1:0];
        end
        if (wr_duty) begin
            duty_reg_d = writedata[CNT_W-1:0];
        end
    end

    always_comb begin
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        if (shadow_load) begin
            period_act_d = period_reg_q;
            duty_act_d   = duty_reg_q;
        end
    end

    always_comb begin
        run_d = enable;
        cnt_d = cnt_q;
        if (!active || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A clear coinciding with a wrap takes priority.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (clr_wrap) begin
            wrap_cnt_d = 3'd0;
        end else if (wrap) begin
            wrap_cnt_d = wrap_cnt_q + 3'd1;
        end
    end

    always_comb begin
        pwm_d    = run_q ? (raw ^ invert) : invert;
        status_d = {wrap_cnt_q,
                    (duty_act_q == '0),
                    (duty_act_q > period_act_q),
                    pending,
                    pwm_q,
                    enable};
    end

    always_comb begin
        readdata_d = '0;
        unique case (address)
            AddrCtrl:   readdata_d = {30'b0, ctrl_q};
            AddrPeriod: readdata_d = {{(32 - CNT_W){1'b0}}, period_reg_q};
            AddrDuty:   readdata_d = {{(32 - CNT_W){1'b0}}, duty_reg_q};
            AddrCmd:    readdata_d = {24'b0, status_q};
            default:    readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q       <= '0;
            period_reg_q <= '0;
            duty_reg_q   <= '0;
            period_act_q <= '0;
            duty_act_q   <= '0;
            cnt_q        <= '0;
            run_q        <= 1'b0;
            wrap_cnt_q   <= '0;
            pwm_q        <= 1'b0;
            status_q     <= '0;
            readdata_q   <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            period_reg_q <= period_reg_d;
            duty_reg_q   <= duty_reg_d;
            period_act_q <= period_act_d;
            duty_act_q   <= duty_act_d;
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            wrap_cnt_q   <= wrap_cnt_d;
            pwm_q        <= pwm_d;
            status_q     <= status_d;
            readdata_q   <= readdata_d;
        end
    end

    assign pwm_out  = pwm_q;
    assign status   = status_q;
    assign readdata = readdata_q;

endmodule
